// File: rtl/cv32e40x_pkg.sv
// Shared types for the branch prediction cache: the cache update command
// encoding and the per-instruction prediction metadata carried down the pipe.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    NOP       = 2'b00,
    INCREMENT = 2'b01,
    DECREMENT = 2'b10,
    NEW_ENTRY = 2'b11
  } cache_cmd_e;

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic [1:0]  cnt;
    logic [31:0] target;
  } bpu_meta_t;

  localparam bpu_meta_t BPU_META_EMPTY = '0;

endpackage

// File: rtl/cv32e40x_bpu_update_ctrl_if.sv
// EX-side update port towards the prediction cache plus the redirect request.
// Protocol: no backpressure. cache_cmd_o != NOP marks a valid one-cycle command
// and the cache must accept it; mispredict_o qualifies redirect_pc_o in the same cycle.
interface cv32e40x_bpu_update_ctrl_if;
  import cv32e40x_pkg::*;

  cache_cmd_e  cache_cmd_o;
  logic [31:0] pc_ex_o;
  logic [31:0] target_pc_ex_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output cache_cmd_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o
  );

  modport slave (
    input cache_cmd_o, pc_ex_o, target_pc_ex_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/cv32e40x_bpu_meta_pipe.sv
// Two-slot (ID, EX) pipe carrying prediction metadata alongside the instruction.
// A killed instruction still advances, but lands as an invalid slot.
module cv32e40x_bpu_meta_pipe
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_advance_i,
  input  logic        pred_hit_i,
  input  logic [1:0]  pred_cnt_i,
  input  logic [31:0] pred_target_i,
  input  logic        id_ex_advance_i,
  input  logic        kill_id_i,
  input  logic        kill_ex_i,
  output bpu_meta_t   ex_meta_o
);

  bpu_meta_t id_q;
  bpu_meta_t ex_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= BPU_META_EMPTY;
      ex_q <= BPU_META_EMPTY;
    end else begin
      if (kill_id_i) begin
        id_q <= BPU_META_EMPTY;
      end else if (if_id_advance_i) begin
        id_q <= '{valid: 1'b1, hit: pred_hit_i, cnt: pred_cnt_i, target: pred_target_i};
      end else if (id_ex_advance_i) begin
        id_q <= BPU_META_EMPTY;
      end

      // A kill of the ID occupant travels with it into EX.
      if (kill_ex_i) begin
        ex_q <= BPU_META_EMPTY;
      end else if (id_ex_advance_i) begin
        ex_q <= kill_id_i ? BPU_META_EMPTY : id_q;
      end
    end
  end

  assign ex_meta_o = ex_q;

endmodule

// File: rtl/cv32e40x_bpu_update_ctrl.sv
// Compares the EX-stage prediction with the resolved branch, issues one cache
// update per branch, raises the redirect, and keeps prediction statistics.
module cv32e40x_bpu_update_ctrl
  import cv32e40x_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_id_advance_i,
  input  logic                        pred_hit_i,
  input  logic [1:0]                  pred_cnt_i,
  input  logic [31:0]                 pred_target_i,
  input  logic                        id_ex_advance_i,
  input  logic                        kill_id_i,
  input  logic                        kill_ex_i,
  input  logic                        ex_resolved_i,
  input  logic                        ex_taken_i,
  input  logic [31:0]                 ex_target_i,
  input  logic [31:0]                 ex_seq_pc_i,
  input  logic [31:0]                 pc_ex_i,
  cv32e40x_bpu_update_ctrl_if.master  upd,
  output logic [CNT_W-1:0]            num_branches_o,
  output logic [CNT_W-1:0]            num_predictions_o,
  output logic [CNT_W-1:0]            num_correct_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bpu_meta_t   ex_meta;
  logic        done_q;
  logic        resolve;
  logic        hit;
  logic        pt;
  logic        tgt_match;
  logic        mispredict;
  cache_cmd_e  cmd_d;
  cache_cmd_e  cmd_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [CNT_W-1:0] branches_q;
  logic [CNT_W-1:0] predictions_q;
  logic [CNT_W-1:0] correct_q;

  cv32e40x_bpu_meta_pipe u_meta_pipe (
    .clk             (clk),
    .rst             (rst),
    .if_id_advance_i (if_id_advance_i),
    .pred_hit_i      (pred_hit_i),
    .pred_cnt_i      (pred_cnt_i),
    .pred_target_i   (pred_target_i),
    .id_ex_advance_i (id_ex_advance_i),
    .kill_id_i       (kill_id_i),
    .kill_ex_i       (kill_ex_i),
    .ex_meta_o       (ex_meta)
  );

  always_comb begin
    // done_q suppresses repeats while EX stalls with the outcome held.
    resolve    = ex_resolved_i & ~done_q;
    hit        = ex_meta.valid & ex_meta.hit;
    pt         = hit & ex_meta.cnt[1];
    tgt_match  = (ex_meta.target == ex_target_i);
    mispredict = resolve & ((pt != ex_taken_i) | (pt & ex_taken_i & ~tgt_match));
    cmd_d      = NOP;
    if (ex_taken_i) begin
      cmd_d = (hit & tgt_match) ? INCREMENT : NEW_ENTRY;
    end else if (hit) begin
      cmd_d = DECREMENT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q        <= 1'b0;
      cmd_q         <= NOP;
      pc_q          <= '0;
      tgt_q         <= '0;
      branches_q    <= '0;
      predictions_q <= '0;
      correct_q     <= '0;
    end else begin
      // A new EX occupant (or a flush) re-arms; the resolve uses the old slot.
      if (id_ex_advance_i | kill_ex_i) begin
        done_q <= 1'b0;
      end else if (resolve) begin
        done_q <= 1'b1;
      end

      if (resolve) begin
        cmd_q <= cmd_d;
        pc_q  <= pc_ex_i;
        tgt_q <= ex_target_i;
        if (branches_q != CNT_MAX) branches_q <= branches_q + CNT_W'(1);
        if (hit && predictions_q != CNT_MAX) predictions_q <= predictions_q + CNT_W'(1);
        if (hit && !mispredict && correct_q != CNT_MAX) correct_q <= correct_q + CNT_W'(1);
      end else begin
        cmd_q <= NOP;
        pc_q  <= '0;
        tgt_q <= '0;
      end
    end
  end

  assign upd.cache_cmd_o    = cmd_q;
  assign upd.pc_ex_o        = pc_q;
  assign upd.target_pc_ex_o = tgt_q;
  assign upd.mispredict_o   = mispredict;
  assign upd.redirect_pc_o  = resolve ? (ex_taken_i ? ex_target_i : ex_seq_pc_i) : 32'h0;

  assign num_branches_o    = branches_q;
  assign num_predictions_o = predictions_q;
  assign num_correct_o     = correct_q;

endmodule

// File: tb/tb_cv32e40x_bpu_update_ctrl.sv
// Directed bench for the branch-resolution update controller with hand-computed expectations.
module tb_cv32e40x_bpu_update_ctrl;
  import cv32e40x_pkg::*;

  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_advance_i;
  logic        pred_hit_i;
  logic [1:0]  pred_cnt_i;
  logic [31:0] pred_target_i;
  logic        id_ex_advance_i;
  logic        kill_id_i;
  logic        kill_ex_i;
  logic        ex_resolved_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic [31:0] ex_seq_pc_i;
  logic [31:0] pc_ex_i;
  logic [CNT_W-1:0] num_branches_o;
  logic [CNT_W-1:0] num_predictions_o;
  logic [CNT_W-1:0] num_correct_o;

  int total = 0;
  int bad   = 0;

  cv32e40x_bpu_update_ctrl_if bus ();

  cv32e40x_bpu_update_ctrl #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_advance_i   (if_id_advance_i),
    .pred_hit_i        (pred_hit_i),
    .pred_cnt_i        (pred_cnt_i),
    .pred_target_i     (pred_target_i),
    .id_ex_advance_i   (id_ex_advance_i),
    .kill_id_i         (kill_id_i),
    .kill_ex_i         (kill_ex_i),
    .ex_resolved_i     (ex_resolved_i),
    .ex_taken_i        (ex_taken_i),
    .ex_target_i       (ex_target_i),
    .ex_seq_pc_i       (ex_seq_pc_i),
    .pc_ex_i           (pc_ex_i),
    .upd               (bus.master),
    .num_branches_o    (num_branches_o),
    .num_predictions_o (num_predictions_o),
    .num_correct_o     (num_correct_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic hit, input logic [1:0] cnt, input logic [31:0] tgt);
    if_id_advance_i = 1'b1;
    pred_hit_i      = hit;
    pred_cnt_i      = cnt;
    pred_target_i   = tgt;
    tick();
    if_id_advance_i = 1'b0;
  endtask

  task automatic advance();
    id_ex_advance_i = 1'b1;
    tick();
    id_ex_advance_i = 1'b0;
  endtask

  task automatic counters(input string tag, input int b, input int p, input int c);
    chk({tag, "_branches"},    num_branches_o,    32'(b));
    chk({tag, "_predictions"}, num_predictions_o, 32'(p));
    chk({tag, "_correct"},     num_correct_o,     32'(c));
  endtask

  // One resolve cycle: check the combinational redirect, then the registered command.
  task automatic resolve(input string tag, input logic taken, input logic [31:0] tgt,
                         input logic [31:0] seq, input logic [31:0] pc,
                         input logic exp_mp, input logic [31:0] exp_redir,
                         input cache_cmd_e exp_cmd);
    ex_resolved_i = 1'b1;
    ex_taken_i    = taken;
    ex_target_i   = tgt;
    ex_seq_pc_i   = seq;
    pc_ex_i       = pc;
    #1;
    chk({tag, "_mispredict"}, 32'(bus.mispredict_o), 32'(exp_mp));
    chk({tag, "_redirect"},   bus.redirect_pc_o,     exp_redir);
    tick();
    ex_resolved_i = 1'b0;
    kill_ex_i     = 1'b0;
    chk({tag, "_cmd"},    32'(bus.cache_cmd_o), 32'(exp_cmd));
    chk({tag, "_pc"},     bus.pc_ex_o,          pc);
    chk({tag, "_target"}, bus.target_pc_ex_o,   tgt);
  endtask

  initial begin
    rst = 1'b1;
    if_id_advance_i = 1'b0; pred_hit_i = 1'b0; pred_cnt_i = 2'b00; pred_target_i = '0;
    id_ex_advance_i = 1'b0; kill_id_i = 1'b0; kill_ex_i = 1'b0;
    ex_resolved_i = 1'b0; ex_taken_i = 1'b0; ex_target_i = '0; ex_seq_pc_i = '0; pc_ex_i = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_cmd",    32'(bus.cache_cmd_o), 32'(NOP));
    chk("rst_pc",     bus.pc_ex_o,          32'h0);
    chk("rst_target", bus.target_pc_ex_o,   32'h0);
    chk("rst_mp",     32'(bus.mispredict_o), 32'h0);
    counters("rst", 0, 0, 0);

    // miss, taken
    fetch(1'b0, 2'b00, 32'h0);
    advance();
    resolve("miss_taken", 1'b1, 32'h80, 32'h104, 32'h100, 1'b1, 32'h80, NEW_ENTRY);
    counters("miss_taken", 1, 0, 0);

    // hit strongly taken, correct target
    fetch(1'b1, 2'b11, 32'h80);
    chk("cmd_one_cycle", 32'(bus.cache_cmd_o), 32'(NOP));
    advance();
    resolve("hit_inc", 1'b1, 32'h80, 32'h204, 32'h200, 1'b0, 32'h80, INCREMENT);
    counters("hit_inc", 2, 1, 1);

    // hit weakly taken, actually not taken
    fetch(1'b1, 2'b10, 32'h80);
    advance();
    resolve("hit_dec", 1'b0, 32'h80, 32'h104, 32'h300, 1'b1, 32'h104, DECREMENT);
    counters("hit_dec", 3, 2, 1);

    // hit taken, wrong cached target
    fetch(1'b1, 2'b11, 32'h80);
    advance();
    resolve("hit_bad_tgt", 1'b1, 32'h90, 32'h404, 32'h400, 1'b1, 32'h90, NEW_ENTRY);
    counters("hit_bad_tgt", 4, 3, 1);

    // EX stall with outcome held for 4 cycles; next branch waits in ID
    fetch(1'b1, 2'b01, 32'h40);
    advance();
    fetch(1'b0, 2'b00, 32'h0);
    resolve("stall", 1'b0, 32'h0, 32'h508, 32'h500, 1'b0, 32'h508, DECREMENT);
    ex_resolved_i = 1'b1;
    #1;
    chk("stall_no_redirect", bus.redirect_pc_o, 32'h0);
    tick();
    chk("stall_cmd2", 32'(bus.cache_cmd_o), 32'(NOP));
    tick();
    chk("stall_cmd3", 32'(bus.cache_cmd_o), 32'(NOP));
    tick();
    chk("stall_cmd4", 32'(bus.cache_cmd_o), 32'(NOP));
    counters("stall", 5, 4, 2);

    // EX advance while still resolved, then new branch resolves
    id_ex_advance_i = 1'b1;
    tick();
    id_ex_advance_i = 1'b0;
    chk("adv_cmd", 32'(bus.cache_cmd_o), 32'(NOP));
    resolve("after_stall", 1'b1, 32'h600, 32'h604, 32'h600, 1'b1, 32'h600, NEW_ENTRY);
    counters("after_stall", 6, 4, 2);

    // killed ID instruction moves into EX as invalid: hit is ignored
    fetch(1'b1, 2'b11, 32'h80);
    id_ex_advance_i = 1'b1;
    kill_id_i       = 1'b1;
    tick();
    id_ex_advance_i = 1'b0;
    kill_id_i       = 1'b0;
    resolve("kill_id", 1'b1, 32'h80, 32'h704, 32'h700, 1'b1, 32'h80, NEW_ENTRY);
    counters("kill_id", 7, 4, 2);

    // flush of EX in the resolve cycle does not cancel the update
    fetch(1'b1, 2'b11, 32'h80);
    advance();
    kill_ex_i = 1'b1;
    resolve("kill_ex", 1'b1, 32'h80, 32'h904, 32'h900, 1'b0, 32'h80, INCREMENT);
    counters("kill_ex", 8, 5, 3);

    // reset one cycle after a resolve
    fetch(1'b0, 2'b00, 32'h0);
    advance();
    resolve("pre_rst", 1'b1, 32'ha0, 32'h804, 32'h800, 1'b1, 32'ha0, NEW_ENTRY);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cmd", 32'(bus.cache_cmd_o), 32'(NOP));
    chk("mid_rst_pc",  bus.pc_ex_o,          32'h0);
    counters("mid_rst", 0, 0, 0);

    // reset in the resolve cycle itself drops the pending command
    fetch(1'b0, 2'b00, 32'h0);
    advance();
    ex_resolved_i = 1'b1;
    ex_taken_i    = 1'b1;
    ex_target_i   = 32'hb0;
    pc_ex_i       = 32'hb00;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
    ex_resolved_i = 1'b0;
    chk("rst_same_cmd", 32'(bus.cache_cmd_o), 32'(NOP));
    counters("rst_same", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40x_bpu_update_ctrl.md
# cv32e40x_bpu_update_ctrl

Branch-resolution side of the BTB/BHT prediction cache: it carries each fetched instruction's prediction metadata from IF to EX, and compares it with the branch outcome computed in EX. It then issues exactly one `cache_cmd` (NOP/INCREMENT/DECREMENT/NEW_ENTRY) per resolved branch to the cache's EX-side update port, and raises the misprediction redirect. It also holds hardware prediction-statistics counters.

## Interface
- `CNT_W`, 32, width of statistics counters.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_id_advance_i`  in  1  IF instruction moves to ID this cycle; capture IF metadata.
- `pred_hit_i`  in  1  cache hit for `pc_if`.
- `pred_cnt_i`  in  2  prediction counter for `pc_if`.
- `pred_target_i`  in  32  cached target for `pc_if`.
- `id_ex_advance_i`  in  1  ID instruction moves to EX.
- `kill_id_i`, `kill_ex_i`  in  1  flush ID / EX metadata slot.
- `ex_resolved_i`  in  1  EX holds a conditional branch with a valid outcome; may be held across stalls.
- `ex_taken_i`  in  1  actual outcome.
- `ex_target_i`  in  32  actual branch target.
- `ex_seq_pc_i`  in  32  sequential next PC (+2/+4).
- `pc_ex_i`  in  32  EX-stage PC.
- `cache_cmd_o`  out  `cache_cmd`  update command to the cache, registered.
- `pc_ex_o`, `target_pc_ex_o`  out  32  registered PC/target accompanying `cache_cmd_o`.
- `mispredict_o`  out  1  combinational flush request.
- `redirect_pc_o`  out  32  correct fetch PC when `mispredict_o`.
- `num_branches_o`, `num_predictions_o`, `num_correct_o`  out  `CNT_W`  statistics.

## Operation
- Metadata pipe: two slots, ID and EX. Each slot is a `bpu_meta_t` {valid, hit, cnt, target}.
  - `if_id_advance_i` loads the ID slot (valid=1).
  - `id_ex_advance_i` copies the ID slot into the EX slot.
  - When `id_ex_advance_i` is high and `if_id_advance_i` is low, the ID slot is invalidated.
  - Kill beats advance into the same slot.
- An invalid EX slot is treated as hit=0.
- `done` flag: set when a command is issued. Cleared on any EX-slot load or kill. A resolution is acted on only when `ex_resolved_i & !done` ("resolve event").
- Predicted taken: `pt = hit & cnt[1]`.
- Command, on a resolve event:
  - hit=0, taken → NEW_ENTRY.
  - hit=0, not taken → NOP.
  - hit=1, taken, target == `ex_target_i` → INCREMENT.
  - hit=1, taken, target differs → NEW_ENTRY.
  - hit=1, not taken → DECREMENT.
- Misprediction, on a resolve event:
  - `mispredict_o` = `(pt != taken) | (pt & taken & target != ex_target_i)`.
  - `redirect_pc_o` = taken ? `ex_target_i` : `ex_seq_pc_i`.
- Statistics, on a resolve event:
  - `num_branches_o` increments.
  - If hit=1: `num_predictions_o` increments; `num_correct_o` increments when `mispredict_o`=0.
  - Counters saturate at all-ones.

## Timing
- Reset values: `cache_cmd_o`=NOP, `pc_ex_o`=`target_pc_ex_o`=0, counters 0, both slots invalid, `done`=0.
- `mispredict_o`/`redirect_pc_o` are valid in the same cycle as the resolve event. Both are 0 otherwise.
- `cache_cmd_o`, `pc_ex_o`, `target_pc_ex_o` are registered from the resolve event: visible one cycle later, held for exactly one cycle, NOP otherwise. The cache write lands on the following edge.
- Back-to-back branches (resolve, EX advance, resolve) produce commands on consecutive cycles.
- A resolve event in the same cycle as `id_ex_advance_i` uses the pre-edge EX slot; the new occupant starts with `done`=0.
- `kill_ex_i` in the same cycle as a resolve event: the command and counters still take effect. Flush does not cancel a resolved update.
- `rst` mid-operation: the pending registered command is dropped (NOP next cycle); counters clear.

## Structure
- `cv32e40x_pkg`: add `bpu_meta_t`. Reuse the existing `cache_cmd` enum; no new encodings.
- Sub-module `cv32e40x_bpu_meta_pipe`: the two-slot metadata pipe with advance/kill. The top block holds the compare logic, `done`, the output register and the counters.

## Test plan
- Miss, then taken at EX with pc_ex=0x100, target=0x80 → next cycle NEW_ENTRY, pc_ex_o=0x100, target_pc_ex_o=0x80; mispredict_o=1, redirect=0x80.
- Hit, cnt=2'b11, target 0x80, taken to 0x80 → INCREMENT, mispredict_o=0; predictions=1, correct=1.
- Hit, cnt=2'b10, not taken, seq_pc=0x104 → DECREMENT, mispredict_o=1, redirect=0x104; correct unchanged.
- Hit, cnt=2'b11, taken to 0x90 but cached 0x80 → NEW_ENTRY, target_pc_ex_o=0x90, mispredict_o=1.
- `ex_resolved_i` held 4 cycles (EX stall) → exactly one command, branches +1. Then EX advance plus a new resolve → second command.
- `kill_id_i` with `id_ex_advance_i` → EX slot invalid; the following taken resolve gives NEW_ENTRY. Assert `rst` one cycle after a resolve → `cache_cmd_o`=NOP, counters 0.
